regfile_clr_bypass: RTL and testbench

- Next-generation synthesized multi-port register file for vanilla-core integer and float register files.
- Adds a registered, stable read output with write-to-read bypass, plus a hardware clear sequencer that zeroes all entries after reset or on request.
- Adds a ready indication and robust out-of-range address handling.
- Sits between the core's decode/writeback stages and the scoreboard.

---
 rtl/regfile_clr_bypass.sv | 126 ++++++++++++
 tb/tb_regfile_clr_bypass.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_clr_bypass.sv
// Multi-port register file with registered read outputs, write-first bypass and a
// clear sequencer that zeroes every entry after reset or on request.
module regfile_clr_bypass #(
    parameter int unsigned width_p           = 32,
    parameter int unsigned els_p             = 32,
    parameter int unsigned num_rd_p          = 1,
    parameter int unsigned num_rs_p          = 2,
    parameter int unsigned x0_tied_to_zero_p = 1,
    parameter int unsigned clear_on_reset_p  = 1,
    localparam int unsigned addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   clear_i,
    output logic                                   ready_o,
    input  logic [num_rd_p-1:0]                    w_v_i,
    input  logic [num_rd_p-1:0][addr_width_lp-1:0] w_addr_i,
    input  logic [num_rd_p-1:0][width_p-1:0]       w_data_i,
    input  logic [num_rs_p-1:0]                    r_v_i,
    input  logic [num_rs_p-1:0][addr_width_lp-1:0] r_addr_i,
    output logic [num_rs_p-1:0][width_p-1:0]       r_data_o,
    output logic [num_rs_p-1:0]                    r_v_o
);

    localparam logic [0:0] state_clear_lp = 1'b0;
    localparam logic [0:0] state_ready_lp = 1'b1;
    localparam logic [0:0] state_reset_lp = (clear_on_reset_p != 0) ? state_clear_lp
                                                                     : state_ready_lp;

    logic [0:0]                       state_q, state_d;
    logic [addr_width_lp-1:0]         cnt_q, cnt_d;
    logic                             ready_q, ready_d;
    logic [num_rs_p-1:0]              r_v_q, r_v_d;
    logic [num_rs_p-1:0][width_p-1:0] r_data_q, r_data_d;
    logic [width_p-1:0]               mem_q [els_p];
    logic [num_rd_p-1:0]              w_en_c;
    logic                             in_ready_c;

    assign in_ready_c = (state_q == state_ready_lp);

    // A write commits only in READY, in range, and never to the tied-zero entry.
    always_comb begin
        w_en_c = '0;
        for (int i = 0; i < num_rd_p; i++) begin
            w_en_c[i] = in_ready_c && w_v_i[i]
                        && (32'(w_addr_i[i]) < els_p)
                        && !((x0_tied_to_zero_p != 0) && (w_addr_i[i] == '0));
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        r_v_d    = '0;
        r_data_d = r_data_q;
        case (state_q)
            state_clear_lp: begin
                cnt_d = cnt_q + addr_width_lp'(1);
                if (32'(cnt_q) == els_p - 1) begin
                    state_d = state_ready_lp;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (clear_i) begin
                    state_d = state_clear_lp;
                    cnt_d   = '0;
                end
                // Later write ports override earlier ones, matching the storage update order.
                for (int j = 0; j < num_rs_p; j++) begin
                    if (r_v_i[j]) begin
                        r_v_d[j]    = 1'b1;
                        r_data_d[j] = '0;
                        if ((32'(r_addr_i[j]) < els_p)
                            && !((x0_tied_to_zero_p != 0) && (r_addr_i[j] == '0))) begin
                            r_data_d[j] = mem_q[r_addr_i[j]];
                            for (int i = 0; i < num_rd_p; i++) begin
                                if (w_en_c[i] && (w_addr_i[i] == r_addr_i[j])) begin
                                    r_data_d[j] = w_data_i[i];
                                end
                            end
                        end
                    end
                end
            end
        endcase
        ready_d = (state_d == state_ready_lp);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= state_reset_lp;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            r_v_q    <= '0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            r_v_q    <= r_v_d;
            r_data_q <= r_data_d;
        end
    end

    // Storage has no reset; the clear sequencer is what initialises it.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if (state_q == state_clear_lp) begin
                mem_q[cnt_q] <= '0;
            end else begin
                for (int i = 0; i < num_rd_p; i++) begin
                    if (w_en_c[i]) begin
                        mem_q[w_addr_i[i]] <= w_data_i[i];
                    end
                end
            end
        end
    end

    assign ready_o  = ready_q;
    assign r_v_o    = r_v_q;
    assign r_data_o = r_data_q;

endmodule

// File: tb/tb_regfile_clr_bypass.sv
// Bench for regfile_clr_bypass: a 32-entry, 2-write/2-read file against a reference
// model, plus a 28-entry file without clear-on-reset for range handling.
module tb_regfile_clr_bypass;

    logic clk;
    logic reset_n;

    logic            a_clear, a_ready;
    logic [1:0]      a_w_v, a_r_v, a_r_v_o;
    logic [1:0][4:0] a_w_addr, a_r_addr;
    logic [1:0][31:0] a_w_data, a_r_data;

    logic             b_clear, b_ready;
    logic [0:0]       b_w_v, b_r_v, b_r_v_o;
    logic [0:0][4:0]  b_w_addr, b_r_addr;
    logic [0:0][31:0] b_w_data, b_r_data;

    int checks = 0;
    int errors = 0;

    logic [31:0]      m_mem [32];
    bit               m_ready;
    int               m_clr_left;
    logic [1:0]       m_rv;
    logic [1:0][31:0] m_rdata;

    regfile_clr_bypass #(
        .width_p(32), .els_p(32), .num_rd_p(2), .num_rs_p(2),
        .x0_tied_to_zero_p(1), .clear_on_reset_p(1)
    ) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .clear_i(a_clear), .ready_o(a_ready),
        .w_v_i(a_w_v), .w_addr_i(a_w_addr), .w_data_i(a_w_data),
        .r_v_i(a_r_v), .r_addr_i(a_r_addr), .r_data_o(a_r_data), .r_v_o(a_r_v_o)
    );

    regfile_clr_bypass #(
        .width_p(32), .els_p(28), .num_rd_p(1), .num_rs_p(1),
        .x0_tied_to_zero_p(1), .clear_on_reset_p(0)
    ) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .clear_i(b_clear), .ready_o(b_ready),
        .w_v_i(b_w_v), .w_addr_i(b_w_addr), .w_data_i(b_w_data),
        .r_v_i(b_r_v), .r_addr_i(b_r_addr), .r_data_o(b_r_data), .r_v_o(b_r_v_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of dut_a: drive, advance the model by the spec rules, then compare.
    task automatic step_a(input bit rst_n, input bit clr, input logic [1:0] wv,
                          input logic [4:0] wa0, input logic [31:0] wd0,
                          input logic [4:0] wa1, input logic [31:0] wd1,
                          input logic [1:0] rv, input logic [4:0] ra0, input logic [4:0] ra1);
        @(negedge clk);
        reset_n     = rst_n;
        a_clear     = clr;
        a_w_v       = wv;
        a_w_addr[0] = wa0;
        a_w_data[0] = wd0;
        a_w_addr[1] = wa1;
        a_w_data[1] = wd1;
        a_r_v       = rv;
        a_r_addr[0] = ra0;
        a_r_addr[1] = ra1;
        if (!rst_n) begin
            m_ready    = 1'b0;
            m_clr_left = 32;
            m_rv       = '0;
            m_rdata    = '0;
            foreach (m_mem[k]) m_mem[k] = '0;
        end else if (!m_ready) begin
            m_rv = '0;
            m_clr_left--;
            if (m_clr_left == 0) m_ready = 1'b1;
        end else begin
            if (wv[0] && wa0 != 0) m_mem[wa0] = wd0;
            if (wv[1] && wa1 != 0) m_mem[wa1] = wd1;
            m_rv = rv;
            if (rv[0]) m_rdata[0] = (ra0 == 0) ? 32'd0 : m_mem[ra0];
            if (rv[1]) m_rdata[1] = (ra1 == 0) ? 32'd0 : m_mem[ra1];
            if (clr) begin
                m_ready    = 1'b0;
                m_clr_left = 32;
                foreach (m_mem[k]) m_mem[k] = '0;
            end
        end
        @(posedge clk);
        #1;
        chk("a_ready", 32'(a_ready), 32'(m_ready));
        chk("a_r_v", 32'(a_r_v_o), 32'(m_rv));
        chk("a_r_data0", a_r_data[0], m_rdata[0]);
        chk("a_r_data1", a_r_data[1], m_rdata[1]);
    endtask

    task automatic idle_a();
        step_a(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    endtask

    task automatic step_b(input bit clr, input bit wv, input logic [4:0] wa,
                          input logic [31:0] wd, input bit rv, input logic [4:0] ra);
        @(negedge clk);
        b_clear     = clr;
        b_w_v       = wv;
        b_w_addr[0] = wa;
        b_w_data[0] = wd;
        b_r_v       = rv;
        b_r_addr[0] = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        reset_n  = 1'b0;
        a_clear  = 1'b0; a_w_v = '0; a_w_addr = '0; a_w_data = '0; a_r_v = '0; a_r_addr = '0;
        b_clear  = 1'b0; b_w_v = '0; b_w_addr = '0; b_w_data = '0; b_r_v = '0; b_r_addr = '0;

        repeat (2) step_a(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        chk("b_reset_ready", 32'(b_ready), 32'd0);
        chk("b_reset_r_v", 32'(b_r_v_o), 32'd0);
        chk("b_reset_r_data", b_r_data[0], 32'd0);

        // Power-up clear with junk traffic that must be ignored.
        n = 0;
        do begin
            step_a(1'b1, 1'($urandom), 2'($urandom), 5'($urandom), $urandom,
                   5'($urandom), $urandom, 2'($urandom), 5'($urandom), 5'($urandom));
            n++;
            if (n == 1) chk("b_ready_no_clear", 32'(b_ready), 32'd1);
        end while (!a_ready && n < 100);
        chk("a_clear_cycles", n, 32);
        idle_a();

        // Second file: explicit clear, then range handling on a non-power-of-two depth.
        step_b(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("b_clear_start", 32'(b_ready), 32'd0);
        n = 0;
        do begin
            step_b(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            n++;
        end while (!b_ready && n < 100);
        chk("b_clear_cycles", n, 28);
        step_b(1'b0, 1'b1, 5'd27, 32'h55, 1'b0, 5'd0);
        step_b(1'b0, 1'b1, 5'd30, 32'h77, 1'b1, 5'd30);
        chk("b_oor_r_v", 32'(b_r_v_o), 32'd1);
        chk("b_oor_bypass", b_r_data[0], 32'd0);
        step_b(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd30);
        chk("b_oor_read", b_r_data[0], 32'd0);
        for (int k = 0; k < 28; k++) begin
            step_b(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(k));
            chk("b_sweep", b_r_data[0], (k == 27) ? 32'h55 : 32'd0);
        end
        step_b(1'b0, 1'b1, 5'd12, 32'h99, 1'b1, 5'd12);
        chk("b_bypass", b_r_data[0], 32'h99);
        step_b(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        for (int k = 0; k < 32; k += 2)
            step_a(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 5'(k), 5'(k + 1));

        step_a(1'b1, 1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 2'b10, 5'd0, 5'd5);
        chk("bypass_deadbeef", a_r_data[1], 32'hDEADBEEF);

        step_a(1'b1, 1'b0, 2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 2'b11, 5'd7, 5'd7);
        chk("conflict_bypass", a_r_data[0], 32'h2222);
        step_a(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 5'd7, 5'd0);
        chk("conflict_stored", a_r_data[0], 32'h2222);

        step_a(1'b1, 1'b0, 2'b01, 5'd0, 32'hFFFF, 5'd0, 32'd0, 2'b01, 5'd0, 5'd0);
        chk("x0_bypass", a_r_data[0], 32'd0);
        step_a(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b10, 5'd0, 5'd0);
        chk("x0_read", a_r_data[1], 32'd0);

        step_a(1'b1, 1'b0, 2'b01, 5'd3, 32'hA, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        step_a(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 5'd3, 5'd0);
        chk("hold_first", a_r_data[0], 32'hA);
        step_a(1'b1, 1'b0, 2'b10, 5'd0, 32'd0, 5'd3, 32'hB, 2'b00, 5'd0, 5'd0);
        chk("hold_data", a_r_data[0], 32'hA);
        chk("hold_r_v", 32'(a_r_v_o), 32'd0);
        idle_a();
        step_a(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 5'd3, 5'd0);
        chk("hold_reread", a_r_data[0], 32'hB);

        for (int k = 0; k < 400; k++)
            step_a(1'b1, ($urandom_range(0, 63) == 0), 2'($urandom), 5'($urandom), $urandom,
                   5'($urandom), $urandom, 2'($urandom), 5'($urandom), 5'($urandom));
        n = 0;
        while (!m_ready && n < 100) begin
            idle_a();
            n++;
        end

        // Fill, request a clear, then reset partway through the sequence.
        for (int k = 1; k < 32; k++)
            step_a(1'b1, 1'b0, 2'b01, 5'(k), 32'h100 + 32'(k), 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        step_a(1'b1, 1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        repeat (10) idle_a();
        step_a(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        n = 0;
        do begin
            idle_a();
            n++;
        end while (!a_ready && n < 100);
        chk("a_restart_cycles", n, 32);
        for (int k = 0; k < 32; k += 2) begin
            step_a(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 5'(k), 5'(k + 1));
            chk("a_zero_after_restart", a_r_data[0] | a_r_data[1], 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
